apu_dac_mixer: RTL

// - Parametrised successor to the APU's plain per-channel DAC output packing: instead of exporting raw

---
 rtl/apu_dac_mixer_if.sv | 28 ++
 rtl/apu_dac_mixer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/apu_dac_mixer_if.sv
// Channel/gain/result bundle of the APU DAC mixer.
// master: the side that requests mixes (APU control); slave: the mixer itself.
interface apu_dac_mixer_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned CH_W   = 7,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned OUT_W  = 12
);
  logic                       SAMPLE;
  logic [NUM_CH*CH_W-1:0]     CH_IN;
  logic [NUM_CH*GAIN_W-1:0]   GAIN;
  logic                       CLR_DROP;
  logic [OUT_W-1:0]           OUT;
  logic                       OUT_VALID;
  logic                       BUSY;
  logic                       DROP;
  logic                       CLIP;

  modport master (
    output SAMPLE, CH_IN, GAIN, CLR_DROP,
    input  OUT, OUT_VALID, BUSY, DROP, CLIP
  );

  modport slave (
    input  SAMPLE, CH_IN, GAIN, CLR_DROP,
    output OUT, OUT_VALID, BUSY, DROP, CLIP
  );
endinterface

// File: rtl/apu_dac_mixer.sv
// APU DAC mixer: time-multiplexed weighted sum of NUM_CH unsigned channel
// levels, one multiply-accumulate per clock, result strobed with OUT_VALID.
// Optional feature: define DAC_MIX_CLAMP_EN to saturate overrange results
// (OUT all ones, CLIP=1); otherwise the result wraps modulo 2^OUT_W and CLIP=0.
module apu_dac_mixer #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned CH_W   = 7,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned OUT_W  = 12,
  parameter int unsigned SHIFT  = 0
) (
  input  logic            CLK,
  input  logic            n_RES,
  apu_dac_mixer_if.slave  bus
);

  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PROD_W = CH_W + GAIN_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [CH_W-1:0]      ch_q   [NUM_CH];
  logic [GAIN_W-1:0]    gain_q [NUM_CH];
  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc;

  logic [PROD_W-1:0]    prod;
  logic [ACC_W-1:0]     sum;
  logic [ACC_W-1:0]     scaled;
  logic                 accept;
  logic                 last;
  logic                 busy_hit;
  logic [OUT_W-1:0]     out_nxt;
  logic                 clip_nxt;

  logic [OUT_W-1:0]     out_q;
  logic                 valid_q;
  logic                 clip_q;
  logic                 drop_q;

  // Per-cycle MAC term, final-sum scaling and range handling
  always_comb begin
    accept   = bus.SAMPLE && (state != ACC);
    busy_hit = bus.SAMPLE && (state == ACC);
    last     = (state == ACC) && (idx == IDX_W'(NUM_CH - 1));
    prod     = PROD_W'(ch_q[idx]) * PROD_W'(gain_q[idx]);
    sum      = acc + ACC_W'(prod);
    scaled   = sum >> SHIFT;
`ifdef DAC_MIX_CLAMP_EN
    if ({{OUT_W{1'b0}}, scaled} > {{ACC_W{1'b0}}, {OUT_W{1'b1}}}) begin
      out_nxt  = '1;
      clip_nxt = 1'b1;
    end else begin
      out_nxt  = OUT_W'(scaled);
      clip_nxt = 1'b0;
    end
`else
    out_nxt  = OUT_W'(scaled);
    clip_nxt = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!n_RES) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE accepts a new request just like IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: snapshot, accumulate, and result registers.
  // The last MAC's sum is loaded straight into OUT so the strobe lines up
  // with the DONE cycle instead of costing an extra cycle.
  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ch_q[i]   <= '0;
        gain_q[i] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          ch_q[i]   <= bus.CH_IN[i*CH_W +: CH_W];
          gain_q[i] <= bus.GAIN[i*GAIN_W +: GAIN_W];
        end
        acc <= '0;
        idx <= '0;
      end else if (state == ACC) begin
        acc <= sum;
        if (!last) idx <= idx + IDX_W'(1);
      end

      valid_q <= last;
      clip_q  <= last ? clip_nxt : 1'b0;
      if (last) out_q <= out_nxt;

      if (busy_hit)          drop_q <= 1'b1;
      else if (bus.CLR_DROP) drop_q <= 1'b0;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.CLIP      = clip_q;
  assign bus.DROP      = drop_q;
  assign bus.BUSY      = (state == ACC);

endmodule
